io_pad_mux_ctrl: RTL and testbench

IO_PAD_MUX_CTRL -- requirements
Module: io_pad_mux_ctrl

---
 rtl/io_pad_mux_ctrl_if.sv | 21 ++
 rtl/io_pad_mux_ctrl.sv | 162 ++++++++++++++++
 tb/tb_io_pad_mux_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pad_mux_ctrl_if.sv
// Wishbone slave bus bundle for the pad mux controller.
interface io_pad_mux_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/io_pad_mux_ctrl.sv
// Per-pad function mux (GPIO/ALT1/ALT2/input-only) with Wishbone-programmed selects
// and a tri-state guard period whenever a pad's function changes.
module io_pad_mux_ctrl #(
  parameter int unsigned NPADS = 38,
  parameter int unsigned GUARD = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  io_pad_mux_ctrl_if.slave wbs,
  input  logic [NPADS-1:0] gpio_o_i,
  input  logic [NPADS-1:0] gpio_oe_i,
  input  logic [NPADS-1:0] alt1_o_i,
  input  logic [NPADS-1:0] alt1_oe_i,
  input  logic [NPADS-1:0] alt2_o_i,
  input  logic [NPADS-1:0] alt2_oe_i,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic             busy_o
);

  localparam int unsigned SelW = 2 * NPADS;

  typedef enum logic [1:0] {StIdle, StGuard, StCommit} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SelW-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic              lock_q, lock_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NPADS-1:0]  io_out_q, io_out_d, io_oeb_q, io_oeb_d;

  logic [2:0]  word;
  logic        is_sel, req, stall, accept;
  logic [95:0] sel_rd;
  logic        unused_adr;

  assign word       = wbs.wbs_adr_i[4:2];
  assign unused_adr = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};
  assign is_sel     = (word < 3'd3);
  assign req        = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  // SEL writes wait out a switch; everything else is served immediately.
  assign stall      = is_sel & wbs.wbs_we_i & busy_o;
  assign accept     = req & ~stall;
  assign sel_rd     = 96'(shadow_q);

  assign busy_o        = (state_q != StIdle);
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign io_out        = io_out_q;
  assign io_oeb        = io_oeb_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      io_out_q <= '0;
      io_oeb_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      lock_q   <= lock_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
    end
  end

  // Register access
  always_comb begin
    shadow_d = shadow_q;
    lock_d   = lock_q;
    ack_d    = 1'b0;
    dat_d    = '0;
    if (accept) begin
      ack_d = 1'b1;
      if (wbs.wbs_we_i) begin
        if (is_sel && !lock_q) begin
          for (int i = 0; i < int'(SelW); i++) begin
            if (int'(word) == i / 32 && wbs.wbs_sel_i[(i % 32) / 8]) begin
              shadow_d[i] = wbs.wbs_dat_i[i % 32];
            end
          end
        end else if (word == 3'd3 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) begin
          lock_d = 1'b1;
        end
      end else begin
        case (word)
          3'd0:    dat_d = sel_rd[31:0];
          3'd1:    dat_d = sel_rd[63:32];
          3'd2:    dat_d = sel_rd[95:64];
          3'd3:    dat_d = {31'b0, lock_q};
          3'd4:    dat_d = {30'b0, lock_q, busy_o};
          default: dat_d = '0;
        endcase
      end
    end
  end

  // Switch sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      StIdle: begin
        if (shadow_q != active_q) begin
          state_d = StGuard;
          cnt_d   = 4'(GUARD - 1);
        end
      end
      StGuard: begin
        if (cnt_q == 4'd0) state_d = StCommit;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StCommit: begin
        active_d = shadow_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad mux; changing pads stay tri-stated through COMMIT so the old function never reappears.
  always_comb begin
    io_out_d = '0;
    io_oeb_d = '1;
    for (int n = 0; n < int'(NPADS); n++) begin
      case (active_q[2*n +: 2])
        2'd0: begin
          io_out_d[n] = gpio_o_i[n];
          io_oeb_d[n] = ~gpio_oe_i[n];
        end
        2'd1: begin
          io_out_d[n] = alt1_o_i[n];
          io_oeb_d[n] = ~alt1_oe_i[n];
        end
        2'd2: begin
          io_out_d[n] = alt2_o_i[n];
          io_oeb_d[n] = ~alt2_oe_i[n];
        end
        default: begin
          io_out_d[n] = 1'b0;
          io_oeb_d[n] = 1'b1;
        end
      endcase
      if (busy_o && (shadow_q[2*n +: 2] != active_q[2*n +: 2])) begin
        io_out_d[n] = 1'b0;
        io_oeb_d[n] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_pad_mux_ctrl.sv
// Directed bench for io_pad_mux_ctrl: bus reads are scoreboarded, pad/busy behaviour checked inline.
module tb_io_pad_mux_ctrl;
  localparam int NP = 38;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic [NP-1:0] gpio_o, gpio_oe, alt1_o, alt1_oe, alt2_o, alt2_oe;
  logic [NP-1:0] io_out, io_oeb;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  io_pad_mux_ctrl_if bus();

  io_pad_mux_ctrl #(.NPADS(NP), .GUARD(4)) dut (
    .wb_clk_i  (wb_clk),
    .wb_rst_i  (wb_rst),
    .wbs       (bus),
    .gpio_o_i  (gpio_o),
    .gpio_oe_i (gpio_oe),
    .alt1_o_i  (alt1_o),
    .alt1_oe_i (alt1_oe),
    .alt2_o_i  (alt2_o),
    .alt2_oe_i (alt2_oe),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .busy_o    (busy)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic wb(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat, input logic [31:0] exp, input string name,
                    output int waited);
    bit got = 1'b0;
    exp_q.push_back('{chk: !we, data: exp, name: name});
    @(negedge wb_clk);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = dat;
    waited = 0;
    while (!got && waited < 60) begin
      step();
      waited++;
      got = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (!got) begin
      check({name, "_ack_timeout"}, 64'(0), 64'(1));
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    int w;
    wb(1'b1, adr, sel, dat, 32'h0, "write", w);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    int w;
    wb(1'b0, adr, 4'hF, 32'h0, exp, name, w);
  endtask

  // Counts busy cycles and how many of them show exactly the guarded pad pattern.
  task automatic count_busy(input logic [NP-1:0] pat, output int nb, output int nf);
    int w = 0;
    nb = 0;
    nf = 0;
    while (!busy && w < 30) begin
      step();
      w++;
    end
    check("busy_start", 64'(busy), 64'(1));
    while (busy && nb < 60) begin
      nb++;
      if (io_oeb === pat) nf++;
      step();
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    logic prev_ack = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (bus.wbs_ack_o) begin
        check("ack_single_cycle", 64'(prev_ack), 64'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check(e.name, 64'(bus.wbs_dat_o), 64'(e.data));
        end
      end
      prev_ack = bus.wbs_ack_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, nb, nf, nbusy;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    gpio_oe = '1;
    gpio_o  = 38'h15;
    alt1_o  = '0;
    alt1_oe = '0;
    alt2_o  = '0;
    alt2_oe = '0;

    repeat (3) step();
    check("rst_io_oeb", 64'(io_oeb), 64'({NP{1'b1}}));
    check("rst_io_out", 64'(io_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ack", 64'(bus.wbs_ack_o), 64'(0));
    check("rst_dat", 64'(bus.wbs_dat_o), 64'(0));

    @(negedge wb_clk) wb_rst = 1'b0;
    step();
    check("gpio_io_oeb", 64'(io_oeb), 64'(0));
    check("gpio_io_out", 64'(io_out), 64'(38'h15));
    rd(32'h10, 32'h0, "status_after_reset");
    rd(32'h00, 32'h0, "sel0_after_reset");
    rd(32'h1C, 32'h0, "unmapped_read");

    // Pad 1 -> ALT1
    alt1_o  = 38'h2;
    alt1_oe = 38'h2;
    alt2_oe = 38'h2;
    wr(32'h00, 4'hF, 32'h4);
    count_busy(38'h2, nb, nf);
    check("sw1_busy_cycles", 64'(nb), 64'(5));
    check("sw1_guard_cycles", 64'(nf), 64'(4));
    check("sw1_commit_hold", 64'(io_oeb), 64'(38'h2));
    step();
    check("sw1_io_oeb", 64'(io_oeb), 64'(0));
    check("sw1_io_out", 64'(io_out), 64'(38'h17));
    rd(32'h00, 32'h4, "sel0_readback");

    // Pad 1 -> ALT2, then a SEL1 write issued mid-guard must be held
    wr(32'h00, 4'hF, 32'h8);
    step();
    step();
    wb(1'b1, 32'h04, 4'hF, 32'h5, 32'h0, "sel1_held", w);
    check("sel1_held_wait", 64'(w), 64'(5));
    check("sel1_ack_busy", 64'(busy), 64'(0));
    count_busy(38'h30000, nb, nf);
    check("sw2_busy_cycles", 64'(nb), 64'(5));
    check("sw2_guard_cycles", 64'(nf), 64'(4));
    check("sw2_commit_hold", 64'(io_oeb), 64'(38'h30000));
    step();
    check("sw2_io_oeb", 64'(io_oeb), 64'(38'h30000));
    check("sw2_io_out", 64'(io_out), 64'(38'h15));
    rd(32'h04, 32'h5, "sel1_readback");
    rd(32'h00, 32'h8, "sel0_after_hold");

    // Byte-lane write to SEL2: pads 32-35 -> input-only
    gpio_o = 38'h3C_0000_0015;
    step();
    wr(32'h08, 4'b0001, 32'hFFFF_FFFF);
    count_busy(38'h0F_0003_0000, nb, nf);
    check("sw3_busy_cycles", 64'(nb), 64'(5));
    check("sw3_guard_cycles", 64'(nf), 64'(4));
    step();
    check("sw3_io_oeb", 64'(io_oeb), 64'(38'h0F_0003_0000));
    check("sw3_io_out", 64'(io_out), 64'(38'h30_0000_0015));
    rd(32'h08, 32'hFF, "sel2_byte_lane");

    // Lock
    wr(32'h0C, 4'h1, 32'h1);
    wr(32'h00, 4'hF, 32'hFFFF_FFFF);
    nbusy = 0;
    repeat (8) begin
      step();
      if (busy) nbusy++;
    end
    check("lock_no_busy", 64'(nbusy), 64'(0));
    rd(32'h00, 32'h8, "sel0_locked");
    rd(32'h10, 32'h2, "status_locked");
    rd(32'h0C, 32'h1, "lock_read");

    // Reset clears lock; then abort a switch with reset
    @(negedge wb_clk) wb_rst = 1'b1;
    step();
    @(negedge wb_clk) wb_rst = 1'b0;
    step();
    rd(32'h10, 32'h0, "status_lock_cleared");
    wr(32'h00, 4'hF, 32'h4);
    w = 0;
    while (!busy && w < 30) begin
      step();
      w++;
    end
    wb(1'b0, 32'h10, 4'hF, 32'h0, 32'h1, "status_in_guard", w);
    check("status_no_stall", 64'(w), 64'(1));
    @(negedge wb_clk) wb_rst = 1'b1;
    step();
    check("abort_io_oeb", 64'(io_oeb), 64'({NP{1'b1}}));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge wb_clk) wb_rst = 1'b0;
    step();
    step();
    check("post_abort_io_oeb", 64'(io_oeb), 64'(0));
    check("post_abort_io_out", 64'(io_out), 64'(38'h3C_0000_0015));
    check("post_abort_busy", 64'(busy), 64'(0));
    rd(32'h00, 32'h0, "sel0_after_abort");

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
